ps2_rx_ctrl: RTL and testbench
==============================

Name: ps2_rx_ctrl

Overview:
- Receive controller for the PS/2 keyboard port; sequences the 11-bit frame integrity check.
- Synchronizes and glitch-filters ps2_clk/ps2_data, then shifts in start, 8 data (LSB first), odd parity and stop bits.
- Validates each frame: start=0, stop=1, odd parity over data+parity.
- Folds E0/F0 prefix bytes into flags and emits one registered scancode event per key action to the keyboard decode logic.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronized samples required before filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered falling edge, while mid-frame, before the frame is aborted (1 ms at 50 MHz).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- ps2_clk, input, 1: raw keyboard clock; asynchronous.
- ps2_data, input, 1: raw keyboard data; asynchronous.
- scan_code, output, 8: last accepted scancode byte.
- scan_valid, output, 1: one-cycle pulse; scan_code and flags are valid.
- is_break, output, 1: an F0 prefix preceded this code.
- is_extended, output, 1: an E0 prefix preceded this code.
- frame_err, output, 1: one-cycle pulse on a bad start/stop/parity or a timeout.

Behaviour:
- Reset (synchronous, all state):
  - Outputs: scan_code=0x00, scan_valid=0, is_break=0, is_extended=0, frame_err=0.
  - FSM=IDLE, bit_cnt=0, pending flags cleared, timeout counter 0.
  - Synchronizers and filter preset to 1 (idle bus).
  - Reset mid-frame discards the partial frame and emits no pulse.
- Input conditioning:
  - 2-FF synchronizer on each input.
  - Filtered ps2_clk changes only after FILTER_LEN consecutive equal synchronized samples.
  - fall = filtered clk 1->0 edge, a one-cycle strobe.
  - Data is sampled from synchronized ps2_data in the fall cycle.
- Frame register (11 bits):
  - On each accepted fall, shift right with the new bit entering bit 10.
  - After 11 bits: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
- FSM IDLE:
  - fall with data=0: load as start bit, bit_cnt=1, go RECV.
  - fall with data=1: ignored, stay IDLE.
- FSM RECV:
  - Each fall shifts a bit in, increments bit_cnt and clears the timeout counter.
  - bit_cnt reaching 11 -> go CHECK.
  - Timeout counter increments on every cycle without a fall.
  - Counter reaching TIMEOUT_CYCLES-1 -> frame_err pulse, clear pending flags, go IDLE.
- FSM CHECK (exactly 1 cycle, then IDLE unconditionally):
  - pass = (frame[0]==0) && (frame[10]==1) && (XOR of frame[9:1]==1).
  - pass && data==0xE0: set ext_pending; no output pulse.
  - pass && data==0xF0: set brk_pending; no output pulse.
  - pass && any other byte: scan_valid=1, scan_code=data, is_break=brk_pending, is_extended=ext_pending; then clear both pending flags.
  - fail: frame_err=1, clear both pending flags; scan_code unchanged.
- Latency:
  - 11th fall at cycle N -> CHECK at N+1 -> scan_valid/frame_err high in cycle N+2, low in N+3.
- Output holding:
  - scan_code, is_break and is_extended hold until the next scan_valid.
  - scan_valid and frame_err are never high in the same cycle.
- Timing assumption: a fall cannot coincide with CHECK, because PS/2 bit spacing far exceeds 1 cycle. A fall arriving in CHECK is nevertheless honoured as a possible start bit on the following cycle.
- Width rules:
  - bit_cnt is 4 bits and saturates at 11.
  - Timeout counter width is clog2(TIMEOUT_CYCLES) and does not count in IDLE.

Test Plan:
- Frame for 0x1C (parity 0, start 0, stop 1), clean clocks -> one scan_valid pulse exactly 2 cycles after the 11th fall; scan_code=0x1C, is_break=0, is_extended=0, frame_err never high.
- Sequence F0 then 1C -> no pulse after F0; after 1C, scan_valid with scan_code=0x1C, is_break=1; next frame 0x32 -> is_break=0.
- Sequence E0, F0, 75 -> single scan_valid with scan_code=0x75, is_extended=1, is_break=1.
- 0x1C frame with parity bit flipped to 1 -> frame_err one cycle, no scan_valid, scan_code keeps its prior value; same result when the stop bit is 0.
- 5 bits sent then ps2_clk held high for TIMEOUT_CYCLES -> frame_err pulse, FSM back in IDLE; a following valid 0x1C frame is received correctly. Also: a 2-cycle low glitch on ps2_clk (FILTER_LEN=4) -> no bit sampled.
- reset asserted mid-frame after 6 bits -> all outputs 0 and no pulse; the next full 0x1C frame is decoded normally.

Source files
------------

// File: rtl/ps2_rx_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_rx_ctrl
// Receive controller for a PS/2 keyboard port.
//   - Two-flop synchronizes the raw ps2_clk / ps2_data lines and glitch-filters
//     the clock, producing a one-cycle strobe on each filtered falling edge.
//   - Shifts in an 11-bit frame (start, 8 data LSB first, odd parity, stop),
//     validates it, folds E0/F0 prefixes into flags and emits one registered
//     scancode event per key action.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset (all state)
//   ps2_clk      raw keyboard clock (asynchronous)
//   ps2_data     raw keyboard data (asynchronous)
//   scan_code    last accepted scancode byte (held until next scan_valid)
//   scan_valid   one-cycle pulse: scan_code / is_break / is_extended valid
//   is_break     an F0 prefix preceded this code
//   is_extended  an E0 prefix preceded this code
//   frame_err    one-cycle pulse on bad start/stop/parity or mid-frame timeout
// ---------------------------------------------------------------------------
module ps2_rx_ctrl #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       is_break,
  output logic       is_extended,
  output logic       frame_err
);

  localparam int FW = ($clog2(FILTER_LEN + 1) < 1) ? 1 : $clog2(FILTER_LEN + 1);
  localparam int TW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    BYTE_EXT = 8'hE0;
  localparam logic [7:0]    BYTE_BRK = 8'hF0;

  // -------------------------------------------------------------------------
  // Input synchronizers: bit 0 = ps2_clk, bit 1 = ps2_data. Preset to 1 so a
  // reset never manufactures a falling edge on an idle bus.
  // -------------------------------------------------------------------------
  logic [1:0] raw_in;
  logic [1:0] meta_reg;
  logic [1:0] sync_reg;

  assign raw_in = {ps2_data, ps2_clk};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    always_ff @(posedge clk) begin
      if (reset) begin
        meta_reg[gi] <= 1'b1;
        sync_reg[gi] <= 1'b1;
      end else begin
        meta_reg[gi] <= raw_in[gi];
        sync_reg[gi] <= meta_reg[gi];
      end
    end
  end

  logic clk_sync;
  logic data_bit;
  assign clk_sync = sync_reg[0];
  assign data_bit = sync_reg[1];

  // -------------------------------------------------------------------------
  // Clock glitch filter: the filtered level flips only on the FILTER_LEN-th
  // consecutive synchronized sample that disagrees with it.
  // -------------------------------------------------------------------------
  logic          filt_reg;
  logic          filt_d_reg;
  logic [FW-1:0] flt_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_reg    <= 1'b1;
      filt_d_reg  <= 1'b1;
      flt_cnt_reg <= '0;
    end else begin
      filt_d_reg <= filt_reg;
      if (clk_sync == filt_reg) begin
        flt_cnt_reg <= '0;
      end else if (flt_cnt_reg == FLT_LAST) begin
        filt_reg    <= clk_sync;
        flt_cnt_reg <= '0;
      end else begin
        flt_cnt_reg <= flt_cnt_reg + FW'(1);
      end
    end
  end

  logic fall;
  assign fall = filt_d_reg & ~filt_reg;

  // -------------------------------------------------------------------------
  // Frame FSM
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t        state_reg,      state_next;
  logic [3:0]    bit_cnt_reg,    bit_cnt_next;
  logic [10:0]   frame_reg,      frame_next;
  logic [TW-1:0] to_cnt_reg,     to_cnt_next;
  logic          ext_pend_reg,   ext_pend_next;
  logic          brk_pend_reg,   brk_pend_next;
  logic          start_hold_reg, start_hold_next;
  logic [7:0]    scan_code_reg,  scan_code_next;
  logic          scan_valid_reg, scan_valid_next;
  logic          is_break_reg,   is_break_next;
  logic          is_ext_reg,     is_ext_next;
  logic          frame_err_reg,  frame_err_next;

  logic       frame_ok;
  logic [7:0] frame_byte;

  assign frame_byte = frame_reg[8:1];
  // Start low, stop high, odd parity across data + parity bit.
  assign frame_ok   = ~frame_reg[0] & frame_reg[10] & (^frame_reg[9:1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= 4'd0;
      frame_reg      <= '0;
      to_cnt_reg     <= '0;
      ext_pend_reg   <= 1'b0;
      brk_pend_reg   <= 1'b0;
      start_hold_reg <= 1'b0;
      scan_code_reg  <= 8'h00;
      scan_valid_reg <= 1'b0;
      is_break_reg   <= 1'b0;
      is_ext_reg     <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      frame_reg      <= frame_next;
      to_cnt_reg     <= to_cnt_next;
      ext_pend_reg   <= ext_pend_next;
      brk_pend_reg   <= brk_pend_next;
      start_hold_reg <= start_hold_next;
      scan_code_reg  <= scan_code_next;
      scan_valid_reg <= scan_valid_next;
      is_break_reg   <= is_break_next;
      is_ext_reg     <= is_ext_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    frame_next      = frame_reg;
    to_cnt_next     = to_cnt_reg;
    ext_pend_next   = ext_pend_reg;
    brk_pend_next   = brk_pend_reg;
    start_hold_next = 1'b0;
    scan_code_next  = scan_code_reg;
    scan_valid_next = 1'b0;
    is_break_next   = is_break_reg;
    is_ext_next     = is_ext_reg;
    frame_err_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        to_cnt_next = '0;
        // start_hold_reg carries a start bit whose fall landed in CHECK.
        if ((fall && !data_bit) || start_hold_reg) begin
          frame_next   = {1'b0, frame_reg[10:1]};
          bit_cnt_next = 4'd1;
          state_next   = ST_RECV;
        end
      end

      ST_RECV: begin
        if (fall) begin
          frame_next  = {data_bit, frame_reg[10:1]};
          to_cnt_next = '0;
          if (bit_cnt_reg < 4'd11) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
          if (bit_cnt_reg == 4'd10) begin
            state_next = ST_CHECK;
          end
        end else if (to_cnt_reg == TO_LAST) begin
          // Keyboard stalled mid-frame: abandon it and any prefix state.
          frame_err_next = 1'b1;
          ext_pend_next  = 1'b0;
          brk_pend_next  = 1'b0;
          bit_cnt_next   = 4'd0;
          to_cnt_next    = '0;
          state_next     = ST_IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + TW'(1);
        end
      end

      ST_CHECK: begin
        state_next      = ST_IDLE;
        bit_cnt_next    = 4'd0;
        to_cnt_next     = '0;
        start_hold_next = fall & ~data_bit;
        if (frame_ok) begin
          if (frame_byte == BYTE_EXT) begin
            ext_pend_next = 1'b1;
          end else if (frame_byte == BYTE_BRK) begin
            brk_pend_next = 1'b1;
          end else begin
            scan_valid_next = 1'b1;
            scan_code_next  = frame_byte;
            is_break_next   = brk_pend_reg;
            is_ext_next     = ext_pend_reg;
            ext_pend_next   = 1'b0;
            brk_pend_next   = 1'b0;
          end
        end else begin
          frame_err_next = 1'b1;
          ext_pend_next  = 1'b0;
          brk_pend_next  = 1'b0;
        end
      end

      default: begin
        state_next   = ST_IDLE;
        bit_cnt_next = 4'd0;
        to_cnt_next  = '0;
      end
    endcase
  end

  assign scan_code   = scan_code_reg;
  assign scan_valid  = scan_valid_reg;
  assign is_break    = is_break_reg;
  assign is_extended = is_ext_reg;
  assign frame_err   = frame_err_reg;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx_ctrl
// Self-checking bench for ps2_rx_ctrl. Frames are bit-banged on ps2_clk /
// ps2_data; a byte-level reference model (prefix flags, last code) predicts
// which event each frame produces and what the held outputs must read.
// ---------------------------------------------------------------------------
module tb_ps2_rx_ctrl;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int HALF           = 20;
  // Raw low edge -> pulse: 2 sync flops + FILTER_LEN filter samples give the
  // fall cycle N, and the event is visible in N+2.
  localparam int PULSE_LAT      = 2 + FILTER_LEN + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       is_break;
  logic       is_extended;
  logic       frame_err;

  ps2_rx_ctrl #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .is_break   (is_break),
    .is_extended(is_extended),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int valid_cnt = 0, err_cnt = 0, both_cnt = 0, valid_cyc = 0, err_cyc = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (scan_valid) begin valid_cnt++; valid_cyc = cyc; end
      if (frame_err)  begin err_cnt++;   err_cyc   = cyc; end
      if (scan_valid && frame_err) both_cnt++;
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_code = 8'h00;
  logic       m_brk = 1'b0, m_ext = 1'b0;
  logic       m_out_brk = 1'b0, m_out_ext = 1'b0;
  int         exp_kind;           // 0 = no event, 1 = scan_valid, 2 = frame_err
  int         v_before, e_before, last_low;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par,
                                             input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n, output int low_cyc);
    low_cyc = 0;
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      wait_cycles(HALF / 2);
      ps2_clk = 1'b0;
      low_cyc = cyc;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
      wait_cycles(HALF / 2);
    end
    ps2_data = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit bad);
    if (bad) begin
      exp_kind = 2; m_brk = 1'b0; m_ext = 1'b0;
    end else if (b == 8'hE0) begin
      exp_kind = 0; m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      exp_kind = 0; m_brk = 1'b1;
    end else begin
      exp_kind = 1; m_code = b; m_out_brk = m_brk; m_out_ext = m_ext;
      m_brk = 1'b0; m_ext = 1'b0;
    end
  endtask

  // Send one complete frame and update the model; tests compare afterwards.
  task automatic do_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    v_before = valid_cnt;
    e_before = err_cnt;
    model_frame(b, bad_par | bad_stop);
    send_bits(make_frame(b, bad_par, bad_stop), 11, last_low);
    wait_cycles(12);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wait_cycles(5);
    checks++; if (scan_code !== 8'h00) begin errors++; $display("FAIL reset_scan_code got=%h exp=00", scan_code); end
    checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL reset_scan_valid got=%b exp=0", scan_valid); end
    checks++; if (is_break !== 1'b0) begin errors++; $display("FAIL reset_is_break got=%b exp=0", is_break); end
    checks++; if (is_extended !== 1'b0) begin errors++; $display("FAIL reset_is_extended got=%b exp=0", is_extended); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    reset = 1'b0;
    wait_cycles(10);
    $display("reset: outputs checked");
  endtask

  task automatic test_single;
    do_frame(8'h1C, 1'b0, 1'b0);
    checks++; if (valid_cnt - v_before !== 1) begin errors++; $display("FAIL single_valid_pulses got=%0d exp=1", valid_cnt - v_before); end
    checks++; if (err_cnt - e_before !== 0) begin errors++; $display("FAIL single_err_pulses got=%0d exp=0", err_cnt - e_before); end
    checks++; if (valid_cyc !== last_low + PULSE_LAT) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", valid_cyc, last_low + PULSE_LAT); end
    checks++; if ({scan_code, is_break, is_extended} !== {8'h1C, 1'b0, 1'b0}) begin
      errors++; $display("FAIL single_outputs got=%h/%b/%b exp=1c/0/0", scan_code, is_break, is_extended);
    end
    $display("single: byte=1c code=%h brk=%b ext=%b", scan_code, is_break, is_extended);
  endtask

  task automatic test_prefix;
    logic [7:0] seq [6];
    seq = '{8'hF0, 8'h1C, 8'h32, 8'hE0, 8'hF0, 8'h75};
    for (int i = 0; i < 6; i++) begin
      do_frame(seq[i], 1'b0, 1'b0);
      checks++; if (valid_cnt - v_before !== int'(exp_kind == 1)) begin
        errors++; $display("FAIL prefix_valid[%0d] got=%0d exp=%0d", i, valid_cnt - v_before, int'(exp_kind == 1));
      end
      checks++; if (err_cnt - e_before !== 0) begin errors++; $display("FAIL prefix_err[%0d] got=%0d exp=0", i, err_cnt - e_before); end
      checks++; if ({scan_code, is_break, is_extended} !== {m_code, m_out_brk, m_out_ext}) begin
        errors++; $display("FAIL prefix_outputs[%0d] got=%h/%b/%b exp=%h/%b/%b", i, scan_code, is_break, is_extended, m_code, m_out_brk, m_out_ext);
      end
      $display("prefix: byte=%h code=%h brk=%b ext=%b", seq[i], scan_code, is_break, is_extended);
    end
  endtask

  task automatic test_errors;
    for (int i = 0; i < 3; i++) begin
      // 0: good 0x1C, 1: parity flipped, 2: stop bit low
      do_frame(8'h1C, i == 1, i == 2);
      checks++; if (valid_cnt - v_before !== int'(i == 0)) begin
        errors++; $display("FAIL err_valid[%0d] got=%0d exp=%0d", i, valid_cnt - v_before, int'(i == 0));
      end
      checks++; if (err_cnt - e_before !== int'(i != 0)) begin
        errors++; $display("FAIL err_pulses[%0d] got=%0d exp=%0d", i, err_cnt - e_before, int'(i != 0));
      end
      if (i != 0) begin
        checks++; if (err_cyc !== last_low + PULSE_LAT) begin errors++; $display("FAIL err_latency[%0d] got=%0d exp=%0d", i, err_cyc, last_low + PULSE_LAT); end
      end
      checks++; if (scan_code !== m_code) begin errors++; $display("FAIL err_scan_code[%0d] got=%h exp=%h", i, scan_code, m_code); end
      $display("errors: case=%0d code=%h frame_err_total=%0d", i, scan_code, err_cnt);
    end
  endtask

  task automatic test_timeout;
    int low;
    do_frame(8'hF0, 1'b0, 1'b0);           // leaves a break prefix pending
    v_before = valid_cnt;
    e_before = err_cnt;
    send_bits(make_frame(8'h1C, 1'b0, 1'b0), 5, low);
    wait_cycles(TIMEOUT_CYCLES + 50);
    m_brk = 1'b0; m_ext = 1'b0;
    checks++; if (err_cnt - e_before !== 1) begin errors++; $display("FAIL timeout_err got=%0d exp=1", err_cnt - e_before); end
    checks++; if (valid_cnt - v_before !== 0) begin errors++; $display("FAIL timeout_valid got=%0d exp=0", valid_cnt - v_before); end
    checks++; if (err_cyc < low + TIMEOUT_CYCLES || err_cyc > low + TIMEOUT_CYCLES + 20) begin
      errors++; $display("FAIL timeout_when got=%0d exp=%0d..%0d", err_cyc, low + TIMEOUT_CYCLES, low + TIMEOUT_CYCLES + 20);
    end
    do_frame(8'h1C, 1'b0, 1'b0);
    checks++; if (valid_cnt - v_before !== 1) begin errors++; $display("FAIL timeout_recover got=%0d exp=1", valid_cnt - v_before); end
    checks++; if ({scan_code, is_break, is_extended} !== {8'h1C, 1'b0, 1'b0}) begin
      errors++; $display("FAIL timeout_outputs got=%h/%b/%b exp=1c/0/0", scan_code, is_break, is_extended);
    end
    $display("timeout: err at cycle %0d, next code=%h brk=%b", err_cyc, scan_code, is_break);
  endtask

  task automatic test_glitch;
    // A 2-cycle low pulse with data low would look like a start bit if sampled.
    v_before = valid_cnt;
    e_before = err_cnt;
    ps2_data = 1'b0;
    wait_cycles(3);
    ps2_clk = 1'b0;
    wait_cycles(2);
    ps2_clk = 1'b1;
    wait_cycles(3);
    ps2_data = 1'b1;
    wait_cycles(30);
    do_frame(8'h2B, 1'b0, 1'b0);
    checks++; if (err_cnt - e_before !== 0) begin errors++; $display("FAIL glitch_err got=%0d exp=0", err_cnt - e_before); end
    checks++; if (valid_cnt - v_before !== 1) begin errors++; $display("FAIL glitch_valid got=%0d exp=1", valid_cnt - v_before); end
    checks++; if (scan_code !== 8'h2B) begin errors++; $display("FAIL glitch_code got=%h exp=2b", scan_code); end
    $display("glitch: following code=%h", scan_code);
  endtask

  task automatic test_reset_mid;
    int low;
    do_frame(8'hE0, 1'b0, 1'b0);           // extended prefix pending
    v_before = valid_cnt;
    e_before = err_cnt;
    send_bits(make_frame(8'h1C, 1'b0, 1'b0), 6, low);
    reset = 1'b1;
    wait_cycles(3);
    checks++; if ({scan_code, scan_valid, is_break, is_extended, frame_err} !== 12'h000) begin
      errors++; $display("FAIL rstmid_outputs got=%h/%b/%b/%b/%b exp=00/0/0/0/0", scan_code, scan_valid, is_break, is_extended, frame_err);
    end
    reset = 1'b0;
    m_code = 8'h00; m_brk = 1'b0; m_ext = 1'b0; m_out_brk = 1'b0; m_out_ext = 1'b0;
    wait_cycles(TIMEOUT_CYCLES + 50);
    checks++; if ((valid_cnt - v_before) + (err_cnt - e_before) !== 0) begin
      errors++; $display("FAIL rstmid_pulses got=%0d exp=0", (valid_cnt - v_before) + (err_cnt - e_before));
    end
    do_frame(8'h1C, 1'b0, 1'b0);
    checks++; if (valid_cnt - v_before !== 1) begin errors++; $display("FAIL rstmid_recover got=%0d exp=1", valid_cnt - v_before); end
    checks++; if ({scan_code, is_break, is_extended} !== {8'h1C, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rstmid_outputs2 got=%h/%b/%b exp=1c/0/0", scan_code, is_break, is_extended);
    end
    $display("reset_mid: next code=%h ext=%b", scan_code, is_extended);
  endtask

  task automatic test_random;
    logic [7:0] b;
    int k;
    bit bp, bs;
    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(0, 7);
      if (k == 0)      b = 8'hE0;
      else if (k == 1) b = 8'hF0;
      else             b = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 7) == 0);
      bs = !bp && ($urandom_range(0, 9) == 0);
      do_frame(b, bp, bs);
      checks++; if (valid_cnt - v_before !== int'(exp_kind == 1) || err_cnt - e_before !== int'(exp_kind == 2)) begin
        errors++; $display("FAIL rand_events[%0d] got=v%0d/e%0d exp_kind=%0d", i, valid_cnt - v_before, err_cnt - e_before, exp_kind);
      end
      if (exp_kind != 0) begin
        checks++; if ((exp_kind == 1 ? valid_cyc : err_cyc) !== last_low + PULSE_LAT) begin
          errors++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, (exp_kind == 1 ? valid_cyc : err_cyc), last_low + PULSE_LAT);
        end
      end
      checks++; if ({scan_code, is_break, is_extended} !== {m_code, m_out_brk, m_out_ext}) begin
        errors++; $display("FAIL rand_outputs[%0d] got=%h/%b/%b exp=%h/%b/%b", i, scan_code, is_break, is_extended, m_code, m_out_brk, m_out_ext);
      end
      $display("random: byte=%h badp=%b bads=%b kind=%0d code=%h brk=%b ext=%b", b, bp, bs, exp_kind, scan_code, is_break, is_extended);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_errors();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_random();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL valid_and_err_together got=%0d exp=0", both_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
